wb_arbiter: RTL

- Parametrised writeback stage that merges NUM_SRC independent result producers (ALU, load unit, mul/div, ...) onto the single register-file write port.
- Each source has a valid/ready handshake into a private DEPTH-entry FIFO.
- A round-robin arbiter drains one entry per cycle into a registered writeback output (data, rd, enable).
- Replaces the fixed single-source writeback mux for the out-of-order-completion core.

---
 rtl/wb_arbiter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/wb_arbiter.sv
// wb_arbiter: merges NUM_SRC result producers onto the single register-file write port
// through per-source FIFOs and a round-robin drain. Optional macro: WB_ARB_BYPASS_EN.
module wb_arbiter #(
   parameter int NUM_SRC = 3,
   parameter int XLEN    = 32,
   parameter int DEPTH   = 2,
   parameter int RD_W    = 5
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush_i,
   input  logic [NUM_SRC-1:0]         src_valid_i,
   output logic [NUM_SRC-1:0]         src_ready_o,
   input  logic [NUM_SRC*XLEN-1:0]    src_data_i,
   input  logic [NUM_SRC*RD_W-1:0]    src_rd_i,
   input  logic [NUM_SRC-1:0]         src_wb_en_i,
   output logic [XLEN-1:0]            wb_data_o,
   output logic [RD_W-1:0]            wb_rd_o,
   output logic                       wb_en_o,
   output logic [$clog2(NUM_SRC)-1:0] wb_src_o,
   output logic                       busy_o
);

   localparam int SRC_W = $clog2(NUM_SRC);
   localparam int AW    = $clog2(DEPTH);
   localparam int PTR_W = AW + 1;
   localparam logic [PTR_W-1:0] FULL_XOR = {1'b1, {AW{1'b0}}};

   logic [PTR_W-1:0]   wr_ptr   [NUM_SRC];
   logic [PTR_W-1:0]   rd_ptr   [NUM_SRC];
   logic [XLEN-1:0]    mem_data [NUM_SRC][DEPTH];
   logic [RD_W-1:0]    mem_rd   [NUM_SRC][DEPTH];

   logic [NUM_SRC-1:0] empty;
   logic [NUM_SRC-1:0] full;
   logic [NUM_SRC-1:0] storable;
   logic [NUM_SRC-1:0] push_fire;
   logic [NUM_SRC-1:0] push;
   logic [NUM_SRC-1:0] pop;
   logic [NUM_SRC-1:0] cand;
   logic               bypass_sel;
   logic               grant_valid;
   logic [SRC_W-1:0]   grant_idx;
   logic [SRC_W-1:0]   last_grant;
   logic [XLEN-1:0]    grant_data;
   logic [RD_W-1:0]    grant_rd;

   // Entries with no write enable or targeting x0 complete the handshake but are never stored.
   always_comb begin
      empty    = '0;
      full     = '0;
      storable = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         empty[k]    = (wr_ptr[k] == rd_ptr[k]);
         full[k]     = ((wr_ptr[k] ^ rd_ptr[k]) == FULL_XOR);
         storable[k] = src_wb_en_i[k] && (src_rd_i[k*RD_W +: RD_W] != '0);
      end
   end

   assign src_ready_o = rst ? '0 : ~full;
   assign push_fire   = src_valid_i & src_ready_o;
   assign busy_o      = !(&empty) || wb_en_o;

   always_comb begin
      int               idx;
      logic [SRC_W-1:0] pos;
      idx         = 0;
      pos         = '0;
      cand        = ~empty;
      bypass_sel  = 1'b0;
`ifdef WB_ARB_BYPASS_EN
      // Only when nothing is queued anywhere may an arriving entry skip its FIFO.
      if (&empty) begin
         cand       = push_fire & storable;
         bypass_sel = 1'b1;
      end
`endif
      grant_valid = 1'b0;
      grant_idx   = '0;
      for (int i = 1; i <= NUM_SRC; i++) begin
         idx = int'(last_grant) + i;
         if (idx >= NUM_SRC) idx = idx - NUM_SRC;
         pos = SRC_W'(idx);
         if (!grant_valid && cand[pos]) begin
            grant_valid = 1'b1;
            grant_idx   = pos;
         end
      end
      pop  = '0;
      push = push_fire & storable;
      if (grant_valid) begin
         if (bypass_sel) push[grant_idx] = 1'b0;
         else            pop[grant_idx]  = 1'b1;
      end
      if (bypass_sel) begin
         grant_data = src_data_i[grant_idx*XLEN +: XLEN];
         grant_rd   = src_rd_i[grant_idx*RD_W +: RD_W];
      end else begin
         grant_data = mem_data[grant_idx][rd_ptr[grant_idx][AW-1:0]];
         grant_rd   = mem_rd[grant_idx][rd_ptr[grant_idx][AW-1:0]];
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush_i) begin
         for (int k = 0; k < NUM_SRC; k++) begin
            wr_ptr[k] <= '0;
            rd_ptr[k] <= '0;
         end
      end else begin
         for (int k = 0; k < NUM_SRC; k++) begin
            if (push[k]) wr_ptr[k] <= wr_ptr[k] + 1'b1;
            if (pop[k])  rd_ptr[k] <= rd_ptr[k] + 1'b1;
         end
      end
   end

   // Storage writes during flush/reset are harmless: the pointers are cleared on the same edge.
   always_ff @(posedge clk) begin
      for (int k = 0; k < NUM_SRC; k++) begin
         if (push[k]) begin
            mem_data[k][wr_ptr[k][AW-1:0]] <= src_data_i[k*XLEN +: XLEN];
            mem_rd[k][wr_ptr[k][AW-1:0]]   <= src_rd_i[k*RD_W +: RD_W];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wb_en_o    <= 1'b0;
         wb_data_o  <= '0;
         wb_rd_o    <= '0;
         wb_src_o   <= '0;
         last_grant <= '0;
      end else if (flush_i) begin
         wb_en_o    <= 1'b0;
         last_grant <= '0;
      end else begin
         wb_en_o <= grant_valid;
         if (grant_valid) begin
            wb_data_o  <= grant_data;
            wb_rd_o    <= grant_rd;
            wb_src_o   <= grant_idx;
            last_grant <= grant_idx;
         end
      end
   end

endmodule
